// File: rtl/ysyx_22050243_lsu_if.sv
// Purpose : bundle of the LSU's pipeline-side and memory-side handshake/bus signals.
// Latency : none (wires only).
// Backpressure: carries req/resp ready and mem_req_ready / mem_rsp_valid between the agents.
// Ports   : pipeline request (req_*), pipeline response (resp_*), memory request (mem_req_*,
//           mem_addr/wen/wdata/wmask) and memory response (mem_rsp_valid, mem_rdata).
//           slave = the LSU, master = pipeline plus memory environment.
interface ysyx_22050243_lsu_if #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_wen;
    logic [2:0]            req_funct3;
    logic [ADDR_W-1:0]     req_addr;
    logic [XLEN-1:0]       req_wdata;
    logic                  resp_valid;
    logic                  resp_ready;
    logic [XLEN-1:0]       resp_rdata;
    logic                  resp_err;
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [XLEN-1:0]       mem_wdata;
    logic [XLEN/8-1:0]     mem_wmask;
    logic                  mem_rsp_valid;
    logic [XLEN-1:0]       mem_rdata;

    modport slave (
        input  req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready,
               mem_req_ready, mem_rsp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, resp_err,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );

    modport master (
        output req_valid, req_wen, req_funct3, req_addr, req_wdata, resp_ready,
               mem_req_ready, mem_rsp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, resp_err,
               mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/ysyx_22050243_lsu.sv
// Purpose : EX/MEM load/store unit: lane placement, write mask, load extension, error detection.
// Latency : 3 cycles accept->resp_valid for legal accesses, 1 cycle for errors; plus stall cycles.
// Backpressure: one transaction in flight; req_ready only in IDLE, every stage holds until its handshake.
// Ports   : clk, rst (sync, active-high); bus = ysyx_22050243_lsu_if slave modport.
module ysyx_22050243_lsu #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_22050243_lsu_if.slave    bus
);
    localparam int NB    = XLEN / 8;
    localparam int OFS_W = $clog2(NB);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              wen_q, wen_d;
    logic [2:0]        f3_q, f3_d;
    logic [OFS_W-1:0]  off_q, off_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
    logic [NB-1:0]     mem_wmask_q, mem_wmask_d;
    logic [XLEN-1:0]   rdata_q, rdata_d;
    logic              err_q, err_d;

    // Request decode, evaluated on the incoming request in IDLE.
    logic [1:0]        req_sz;
    logic [OFS_W-1:0]  req_off;
    logic [OFS_W-1:0]  align_m;
    logic              req_err;
    logic [XLEN-1:0]   st_data;
    logic [NB-1:0]     st_mask;

    // Load extraction, evaluated on the memory word in WAIT.
    logic [XLEN-1:0]   ld_shift;
    logic [XLEN-1:0]   ld_mask;
    logic              ld_msb;
    logic [XLEN-1:0]   ld_data;

    always_comb begin
        req_sz  = bus.req_funct3[1:0];
        req_off = bus.req_addr[OFS_W-1:0];
        // Offset bits that must be zero for the access size to be naturally aligned.
        align_m = OFS_W'((32'd1 << req_sz) - 32'd1);
        req_err = (|(req_off & align_m))
                | (bus.req_wen && bus.req_funct3[2])
                | (!bus.req_wen && bus.req_funct3 == 3'b111)
                | (XLEN == 32 && req_sz == 2'b11);

        // Store data is replicated into every lane so lane `off` always carries it.
        case (req_sz)
            2'd0:    st_data = {NB{bus.req_wdata[7:0]}};
            2'd1:    st_data = {(NB/2){bus.req_wdata[15:0]}};
            2'd2:    st_data = {(NB/4){bus.req_wdata[31:0]}};
            default: st_data = bus.req_wdata;
        endcase
        st_mask = NB'((32'd1 << (32'd1 << req_sz)) - 32'd1) << req_off;
    end

    always_comb begin
        ld_shift = bus.mem_rdata >> {off_q, 3'b000};
        case (f3_q[1:0])
            2'd0:    begin ld_mask = XLEN'(8'hFF);         ld_msb = ld_shift[7];      end
            2'd1:    begin ld_mask = XLEN'(16'hFFFF);      ld_msb = ld_shift[15];     end
            2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_msb = ld_shift[31];     end
            default: begin ld_mask = '1;                   ld_msb = ld_shift[XLEN-1]; end
        endcase
        // funct3[2] selects the unsigned variant; otherwise fill above the field with its MSB.
        ld_data = (ld_shift & ld_mask) | ((!f3_q[2] && ld_msb) ? ~ld_mask : '0);
    end

    always_comb begin
        state_d     = state_q;
        wen_d       = wen_q;
        f3_d        = f3_q;
        off_d       = off_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    wen_d   = bus.req_wen;
                    f3_d    = bus.req_funct3;
                    off_d   = req_off;
                    rdata_d = '0;
                    err_d   = req_err;
                    if (req_err) begin
                        state_d = S_RESP;
                    end else begin
                        state_d     = S_REQ;
                        mem_addr_d  = {bus.req_addr[ADDR_W-1:OFS_W], {OFS_W{1'b0}}};
                        mem_wdata_d = bus.req_wen ? st_data : '0;
                        mem_wmask_d = bus.req_wen ? st_mask : '0;
                    end
                end
            end
            S_REQ: begin
                if (bus.mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.mem_rsp_valid) begin
                    rdata_d = wen_q ? '0 : ld_data;
                    state_d = S_RESP;
                end
            end
            default: begin
                if (bus.resp_ready) state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            wen_q       <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wen_q       <= wen_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    assign bus.req_ready     = (state_q == S_IDLE);
    assign bus.mem_req_valid = (state_q == S_REQ);
    assign bus.resp_valid    = (state_q == S_RESP);
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wen       = wen_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign bus.mem_wmask     = mem_wmask_q;
    assign bus.resp_rdata    = rdata_q;
    assign bus.resp_err      = err_q;
endmodule

// File: tb/tb_ysyx_22050243_lsu.sv
module tb_ysyx_22050243_lsu;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [63:0] model_mem = 64'h0;

    ysyx_22050243_lsu_if #(.XLEN(64), .ADDR_W(32)) bus64 ();
    ysyx_22050243_lsu_if #(.XLEN(32), .ADDR_W(32)) bus32 ();

    ysyx_22050243_lsu #(.XLEN(64), .ADDR_W(32)) dut64 (.clk(clk), .rst(rst), .bus(bus64));
    ysyx_22050243_lsu #(.XLEN(32), .ADDR_W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    typedef struct {
        logic        wen;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] mrdata;
        logic        use_mem;
        logic        err;
        logic [63:0] rdata;
        logic [31:0] maddr;
        logic [7:0]  wmask;
        logic [63:0] mwdata;
    } vec_t;

    vec_t tbl [15];

    function automatic vec_t mk(input logic wen, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [63:0] wd, input logic [63:0] mrd, input logic use_mem,
                                input logic err, input logic [63:0] rdata, input logic [31:0] maddr,
                                input logic [7:0] wmask, input logic [63:0] mwd);
        vec_t v;
        v.wen = wen; v.f3 = f3; v.addr = addr; v.wdata = wd; v.mrdata = mrd;
        v.use_mem = use_mem; v.err = err; v.rdata = rdata; v.maddr = maddr;
        v.wmask = wmask; v.mwdata = mwd;
        return v;
    endfunction

    function automatic logic [63:0] expand(input logic [7:0] m);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[8*b +: 8] = {8{m[b]}};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle64();
        bus64.req_valid = 0; bus64.req_wen = 0; bus64.req_funct3 = 0; bus64.req_addr = 0;
        bus64.req_wdata = 0; bus64.resp_ready = 0; bus64.mem_req_ready = 0;
        bus64.mem_rsp_valid = 0; bus64.mem_rdata = 0;
    endtask

    task automatic idle32();
        bus32.req_valid = 0; bus32.req_wen = 0; bus32.req_funct3 = 0; bus32.req_addr = 0;
        bus32.req_wdata = 0; bus32.resp_ready = 0; bus32.mem_req_ready = 0;
        bus32.mem_rsp_valid = 0; bus32.mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle64();
        idle32();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // One transaction on the 64-bit unit, called at a negedge with the unit in IDLE.
    // rq/rs/rp = stall cycles for mem_req_ready, mem_rsp_valid and resp_ready.
    task automatic run_txn(input vec_t v, input int rq, input int rs, input int rp, input string tag);
        chk({tag, "_req_ready_idle"}, bus64.req_ready, 1);
        bus64.req_valid = 1; bus64.req_wen = v.wen; bus64.req_funct3 = v.f3;
        bus64.req_addr = v.addr; bus64.req_wdata = v.wdata;
        bus64.mem_req_ready = 0; bus64.mem_rsp_valid = 0; bus64.resp_ready = 0;
        @(negedge clk);
        bus64.req_valid = 0; bus64.req_wdata = 64'hDEAD_DEAD_DEAD_DEAD; bus64.req_addr = 32'hFFFF_FFFF;
        if (v.err) begin
            chk({tag, "_err_resp_valid"}, bus64.resp_valid, 1);
            chk({tag, "_err_flag"}, bus64.resp_err, 1);
            chk({tag, "_err_rdata"}, bus64.resp_rdata, 0);
            chk({tag, "_err_no_mem_req"}, bus64.mem_req_valid, 0);
            bus64.resp_ready = 1;
            @(negedge clk);
            bus64.resp_ready = 0;
            chk({tag, "_err_resp_done"}, bus64.resp_valid, 0);
            chk({tag, "_err_no_mem_req2"}, bus64.mem_req_valid, 0);
            return;
        end
        for (int i = 0; i <= rq; i++) begin
            chk({tag, "_mem_req_valid"}, bus64.mem_req_valid, 1);
            chk({tag, "_mem_addr"}, bus64.mem_addr, v.maddr);
            chk({tag, "_mem_wen"}, bus64.mem_wen, v.wen);
            chk({tag, "_mem_wmask"}, bus64.mem_wmask, v.wmask);
            if (v.wen) chk({tag, "_mem_wdata"}, bus64.mem_wdata, v.mwdata);
            chk({tag, "_req_ready_busy"}, bus64.req_ready, 0);
            chk({tag, "_resp_early"}, bus64.resp_valid, 0);
            if (i == rq) begin
                bus64.mem_req_ready = 1;
                if (v.wen)
                    model_mem = (model_mem & ~expand(bus64.mem_wmask)) | (bus64.mem_wdata & expand(bus64.mem_wmask));
            end
            @(negedge clk);
        end
        bus64.mem_req_ready = 0;
        bus64.mem_rdata = v.use_mem ? model_mem : v.mrdata;
        for (int i = 0; i <= rs; i++) begin
            chk({tag, "_wait_no_mem_req"}, bus64.mem_req_valid, 0);
            chk({tag, "_wait_resp"}, bus64.resp_valid, 0);
            if (i == rs) bus64.mem_rsp_valid = 1;
            @(negedge clk);
        end
        bus64.mem_rsp_valid = 0;
        bus64.mem_rdata = 64'h5A5A_5A5A_5A5A_5A5A;
        for (int i = 0; i <= rp; i++) begin
            chk({tag, "_resp_valid"}, bus64.resp_valid, 1);
            chk({tag, "_resp_err"}, bus64.resp_err, 0);
            chk({tag, "_resp_rdata"}, bus64.resp_rdata, v.rdata);
            chk({tag, "_req_ready_resp"}, bus64.req_ready, 0);
            if (i == rp) bus64.resp_ready = 1;
            @(negedge clk);
        end
        bus64.resp_ready = 0;
        chk({tag, "_resp_done"}, bus64.resp_valid, 0);
        chk({tag, "_req_ready_after"}, bus64.req_ready, 1);
    endtask

    initial begin
        tbl[0]  = mk(1, 3'b000, 32'h8000_0005, 64'h1234_5678_9ABC_DEF0, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0,
                     64'h0, 32'h8000_0000, 8'h20, 64'hF0F0_F0F0_F0F0_F0F0);
        tbl[1]  = mk(0, 3'b001, 32'h8000_0002, 64'h0, 64'h8899_AABB_CCDD_EEFF, 0, 0,
                     64'hFFFF_FFFF_FFFF_CCDD, 32'h8000_0000, 8'h00, 64'h0);
        tbl[2]  = mk(0, 3'b101, 32'h8000_0002, 64'h0, 64'h8899_AABB_CCDD_EEFF, 0, 0,
                     64'h0000_0000_0000_CCDD, 32'h8000_0000, 8'h00, 64'h0);
        tbl[3]  = mk(0, 3'b010, 32'h8000_0004, 64'h0, 64'h8899_AABB_CCDD_EEFF, 0, 0,
                     64'hFFFF_FFFF_8899_AABB, 32'h8000_0000, 8'h00, 64'h0);
        tbl[4]  = mk(0, 3'b000, 32'h8000_0000, 64'h0, 64'h8899_AABB_CCDD_EEFF, 0, 0,
                     64'hFFFF_FFFF_FFFF_FFFF, 32'h8000_0000, 8'h00, 64'h0);
        tbl[5]  = mk(0, 3'b100, 32'h8000_0007, 64'h0, 64'h8899_AABB_CCDD_EEFF, 0, 0,
                     64'h0000_0000_0000_0088, 32'h8000_0000, 8'h00, 64'h0);
        tbl[6]  = mk(0, 3'b110, 32'h8000_0000, 64'h0, 64'h8899_AABB_CCDD_EEFF, 0, 0,
                     64'h0000_0000_CCDD_EEFF, 32'h8000_0000, 8'h00, 64'h0);
        tbl[7]  = mk(0, 3'b011, 32'h8000_0008, 64'h0, 64'h8899_AABB_CCDD_EEFF, 0, 0,
                     64'h8899_AABB_CCDD_EEFF, 32'h8000_0008, 8'h00, 64'h0);
        tbl[8]  = mk(1, 3'b001, 32'h0000_0006, 64'h1111_2222_3333_BEEF, 64'h0, 0, 0,
                     64'h0, 32'h0000_0000, 8'hC0, 64'hBEEF_BEEF_BEEF_BEEF);
        tbl[9]  = mk(1, 3'b010, 32'h0000_004C, 64'hAAAA_AAAA_1234_5678, 64'h0, 0, 0,
                     64'h0, 32'h0000_0048, 8'hF0, 64'h1234_5678_1234_5678);
        tbl[10] = mk(0, 3'b010, 32'h0000_1002, 64'h0, 64'h0, 0, 1, 64'h0, 32'h0, 8'h0, 64'h0);
        tbl[11] = mk(1, 3'b100, 32'h0000_0020, 64'h55, 64'h0, 0, 1, 64'h0, 32'h0, 8'h0, 64'h0);
        tbl[12] = mk(0, 3'b111, 32'h0000_0020, 64'h0, 64'h0, 0, 1, 64'h0, 32'h0, 8'h0, 64'h0);
        tbl[13] = mk(1, 3'b001, 32'h0000_0003, 64'h77, 64'h0, 0, 1, 64'h0, 32'h0, 8'h0, 64'h0);
        tbl[14] = mk(0, 3'b011, 32'h0000_0014, 64'h0, 64'h0, 0, 1, 64'h0, 32'h0, 8'h0, 64'h0);

        do_reset();

        // Reset state of both widths.
        chk("rst_req_ready", bus64.req_ready, 1);
        chk("rst_resp_valid", bus64.resp_valid, 0);
        chk("rst_resp_err", bus64.resp_err, 0);
        chk("rst_resp_rdata", bus64.resp_rdata, 0);
        chk("rst_mem_req_valid", bus64.mem_req_valid, 0);
        chk("rst_mem_wen", bus64.mem_wen, 0);
        chk("rst_mem_wdata", bus64.mem_wdata, 0);
        chk("rst_mem_wmask", bus64.mem_wmask, 0);
        chk("rst_mem_addr", bus64.mem_addr, 0);
        chk("rst32_req_ready", bus32.req_ready, 1);

        // Directed vectors, each from a fresh reset with no stalls.
        for (int i = 0; i < 15; i++) begin
            do_reset();
            run_txn(tbl[i], 0, 0, 0, $sformatf("v%0d", i));
        end

        // Backpressure: 3 req stalls, 2 rsp stalls, 4 resp stalls; resp_valid lands 8 cycles after accept.
        do_reset();
        run_txn(tbl[3], 3, 2, 4, "bp_lw");
        run_txn(tbl[0], 3, 2, 4, "bp_sb");

        // Back-to-back sd then ld through the memory model.
        do_reset();
        model_mem = 64'h0;
        run_txn(mk(1, 3'b011, 32'h10, 64'hDEAD_BEEF_CAFE_F00D, 64'h0, 0, 0, 64'h0, 32'h10, 8'hFF,
                   64'hDEAD_BEEF_CAFE_F00D), 0, 0, 0, "b2b_sd");
        run_txn(mk(0, 3'b011, 32'h10, 64'h0, 64'h0, 1, 0, 64'hDEAD_BEEF_CAFE_F00D, 32'h10, 8'h00,
                   64'h0), 0, 0, 0, "b2b_ld");

        // Reset while in WAIT drops the transaction.
        do_reset();
        bus64.req_valid = 1; bus64.req_wen = 0; bus64.req_funct3 = 3'b010; bus64.req_addr = 32'h8000_0004;
        @(negedge clk);
        bus64.req_valid = 0; bus64.mem_req_ready = 1;
        @(negedge clk);
        bus64.mem_req_ready = 0;
        chk("midrst_in_wait", bus64.mem_req_valid, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("midrst_req_ready", bus64.req_ready, 1);
        chk("midrst_resp_valid", bus64.resp_valid, 0);
        chk("midrst_mem_req_valid", bus64.mem_req_valid, 0);
        chk("midrst_mem_addr", bus64.mem_addr, 0);
        chk("midrst_mem_wmask", bus64.mem_wmask, 0);
        chk("midrst_resp_err", bus64.resp_err, 0);
        bus64.mem_rsp_valid = 1; bus64.mem_rdata = 64'h8899_AABB_CCDD_EEFF;
        @(negedge clk);
        bus64.mem_rsp_valid = 0;
        chk("midrst_no_resp1", bus64.resp_valid, 0);
        @(negedge clk);
        chk("midrst_no_resp2", bus64.resp_valid, 0);
        chk("midrst_req_ready2", bus64.req_ready, 1);

        // XLEN=32: ld is illegal; lh sign-extends within 32 bits.
        do_reset();
        bus32.req_valid = 1; bus32.req_wen = 0; bus32.req_funct3 = 3'b011; bus32.req_addr = 32'h100;
        @(negedge clk);
        bus32.req_valid = 0;
        chk("x32_ld_resp_valid", bus32.resp_valid, 1);
        chk("x32_ld_err", bus32.resp_err, 1);
        chk("x32_ld_no_mem_req", bus32.mem_req_valid, 0);
        bus32.resp_ready = 1;
        @(negedge clk);
        bus32.resp_ready = 0;
        chk("x32_ld_done", bus32.resp_valid, 0);
        bus32.req_valid = 1; bus32.req_funct3 = 3'b001; bus32.req_addr = 32'h102;
        @(negedge clk);
        bus32.req_valid = 0;
        chk("x32_lh_mem_req", bus32.mem_req_valid, 1);
        chk("x32_lh_mem_addr", bus32.mem_addr, 32'h100);
        chk("x32_lh_mem_wmask", bus32.mem_wmask, 0);
        bus32.mem_req_ready = 1;
        @(negedge clk);
        bus32.mem_req_ready = 0; bus32.mem_rsp_valid = 1; bus32.mem_rdata = 32'h8001_0000;
        @(negedge clk);
        bus32.mem_rsp_valid = 0;
        chk("x32_lh_resp_valid", bus32.resp_valid, 1);
        chk("x32_lh_err", bus32.resp_err, 0);
        chk("x32_lh_rdata", bus32.resp_rdata, 64'h0000_0000_FFFF_8001);
        bus32.resp_ready = 1;
        @(negedge clk);
        bus32.resp_ready = 0;
        chk("x32_lh_done", bus32.resp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
